fetch_pc_unit: RTL and testbench

- Program-counter and fetch-address generator directly upstream of the synchronous instruction memory.
- Drives the memory's word address every cycle.
- Relocates user programs by base/limit: the OS image starts at word 0, and user programs are loaded at physical offsets.
- Handles branch/jump redirects, syscall/fault traps to the OS, stall and halt.
- Tracks which cycles carry a valid instruction, given the memory's one-cycle read latency.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_next_pc.sv | 120 ++++++++++++
 rtl/fetch_pc_unit.sv | 145 ++++++++++++++
 tb/tb_fetch_pc_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch PC unit.
// Optional trace outputs are enabled with FETCH_TRACE_EN.
package fetch_pkg;

  typedef enum logic [1:0] {
    StKernel = 2'd0,
    StUser   = 2'd1,
    StHalted = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RedirNone   = 2'd0,
    RedirBranch = 2'd1,
    RedirJump   = 2'd2,
    RedirTrap   = 2'd3
  } redir_e;

  localparam int unsigned DefaultAw            = 32;
  localparam int unsigned DefaultMemDepth      = 1000;
  localparam int unsigned DefaultSyscallVector = 1;
  localparam int unsigned DefaultFaultVector   = 2;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC priority mux and bounds check for fetch_pc_unit.
// With FETCH_TRACE_EN defined it also reports the redirect source.
module fetch_next_pc import fetch_pkg::*; #(
  parameter int unsigned AW             = DefaultAw,
  parameter int unsigned MEM_DEPTH      = DefaultMemDepth,
  parameter int unsigned SYSCALL_VECTOR = DefaultSyscallVector,
  parameter int unsigned FAULT_VECTOR   = DefaultFaultVector
) (
  input  state_e          state,
  input  state_e          prev_state,
  input  logic [AW-1:0]   pc,
  input  logic [AW-1:0]   base,
  input  logic [AW-1:0]   limit,
  input  logic            valid,
  input  logic            stall,
  input  logic            halt,
  input  logic            resume,
  input  logic            branch_take,
  input  logic [AW-1:0]   branch_off,
  input  logic            jump_take,
  input  logic [AW-1:0]   jump_target,
  input  logic            syscall,
  input  logic            ctx_load,
  input  logic [AW-1:0]   ctx_base,
  input  logic [AW-1:0]   ctx_limit,
  input  logic [AW-1:0]   ctx_pc,
  output state_e          state_d,
  output logic [AW-1:0]   pc_d,
  output logic [AW-1:0]   base_d,
  output logic [AW-1:0]   limit_d,
  output logic            valid_d,
  output logic            saved_en,
  output logic [AW-1:0]   saved_d,
  output logic            fault_set,
  output logic            fault_clr
`ifdef FETCH_TRACE_EN
  ,
  output redir_e          redir
`endif
);

  logic [AW-1:0] phys;
  redir_e        redir_d;

  always_comb begin
    state_d   = state;
    pc_d      = pc;
    base_d    = base;
    limit_d   = limit;
    valid_d   = valid;
    saved_en  = 1'b0;
    saved_d   = '0;
    fault_set = 1'b0;
    fault_clr = 1'b0;
    redir_d   = RedirNone;
    phys      = '0;

    if (state == StHalted) begin
      valid_d = 1'b0;
      if (resume) begin
        state_d = prev_state;
      end
    end else if (halt) begin
      state_d = StHalted;
      valid_d = 1'b0;
    end else if (!stall) begin
      if (ctx_load && state == StKernel) begin
        state_d   = StUser;
        base_d    = ctx_base;
        limit_d   = ctx_limit;
        pc_d      = ctx_pc;
        fault_clr = 1'b1;
        valid_d   = 1'b0;
      end else if (syscall && state == StUser) begin
        state_d  = StKernel;
        saved_en = 1'b1;
        saved_d  = pc + AW'(1);
        pc_d     = AW'(SYSCALL_VECTOR);
        base_d   = '0;
        limit_d  = '1;
        valid_d  = 1'b0;
        redir_d  = RedirTrap;
      end else if (jump_take) begin
        pc_d    = jump_target;
        valid_d = 1'b0;
        redir_d = RedirJump;
      end else if (branch_take) begin
        pc_d    = pc + branch_off;
        valid_d = 1'b0;
        redir_d = RedirBranch;
      end else begin
        pc_d    = pc + AW'(1);
        valid_d = 1'b1;
      end

      // The check applies to the candidate next PC; a violation replaces it with the fault trap.
      phys = base_d + pc_d;
      if ((state_d == StUser && pc_d > limit_d) || phys >= AW'(MEM_DEPTH)) begin
        saved_en  = 1'b1;
        saved_d   = pc_d;
        pc_d      = AW'(FAULT_VECTOR);
        base_d    = '0;
        limit_d   = '1;
        state_d   = StKernel;
        fault_set = 1'b1;
        fault_clr = 1'b0;
        valid_d   = 1'b0;
        redir_d   = RedirTrap;
      end
    end
  end

`ifdef FETCH_TRACE_EN
  assign redir = redir_d;
`else
  logic unused_redir;
  assign unused_redir = ^redir_d;
`endif

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter and relocated fetch-address generator with trap, stall and halt handling.
// Defining FETCH_TRACE_EN adds the trace_count and last_redirect_src outputs.
module fetch_pc_unit import fetch_pkg::*; #(
  parameter int unsigned AW             = DefaultAw,
  parameter int unsigned MEM_DEPTH      = DefaultMemDepth,
  parameter int unsigned SYSCALL_VECTOR = DefaultSyscallVector,
  parameter int unsigned FAULT_VECTOR   = DefaultFaultVector
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          halt,
  input  logic          resume,
  input  logic          branch_take,
  input  logic [AW-1:0] branch_off,
  input  logic          jump_take,
  input  logic [AW-1:0] jump_target,
  input  logic          syscall,
  input  logic          ctx_load,
  input  logic [AW-1:0] ctx_base,
  input  logic [AW-1:0] ctx_limit,
  input  logic [AW-1:0] ctx_pc,
  output logic [AW-1:0] mem_addr,
  output logic [AW-1:0] pc_logical,
  output logic          user_mode,
  output logic          instr_valid,
  output logic [AW-1:0] saved_pc,
  output logic          fault,
  output logic          halted
`ifdef FETCH_TRACE_EN
  ,
  output logic [31:0]   trace_count,
  output logic [1:0]    last_redirect_src
`endif
);

  state_e        state_q, state_d, prev_q;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] limit_q, limit_d;
  logic [AW-1:0] saved_q, saved_d;
  logic          valid_q, valid_d;
  logic          fault_q;
  logic          saved_en, fault_set, fault_clr;
`ifdef FETCH_TRACE_EN
  redir_e        redir_d, redir_q;
  logic [31:0]   trace_q;
`endif

  fetch_next_pc #(
    .AW             (AW),
    .MEM_DEPTH      (MEM_DEPTH),
    .SYSCALL_VECTOR (SYSCALL_VECTOR),
    .FAULT_VECTOR   (FAULT_VECTOR)
  ) u_next_pc (
    .state       (state_q),
    .prev_state  (prev_q),
    .pc          (pc_q),
    .base        (base_q),
    .limit       (limit_q),
    .valid       (valid_q),
    .stall       (stall),
    .halt        (halt),
    .resume      (resume),
    .branch_take (branch_take),
    .branch_off  (branch_off),
    .jump_take   (jump_take),
    .jump_target (jump_target),
    .syscall     (syscall),
    .ctx_load    (ctx_load),
    .ctx_base    (ctx_base),
    .ctx_limit   (ctx_limit),
    .ctx_pc      (ctx_pc),
    .state_d     (state_d),
    .pc_d        (pc_d),
    .base_d      (base_d),
    .limit_d     (limit_d),
    .valid_d     (valid_d),
    .saved_en    (saved_en),
    .saved_d     (saved_d),
    .fault_set   (fault_set),
    .fault_clr   (fault_clr)
`ifdef FETCH_TRACE_EN
    ,
    .redir       (redir_d)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StKernel;
      prev_q  <= StKernel;
      pc_q    <= '0;
      base_q  <= '0;
      limit_q <= '1;
      valid_q <= 1'b0;
      saved_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Remember the running mode so resume can return to it.
      if (state_d == StHalted && state_q != StHalted) begin
        prev_q <= state_q;
      end
      pc_q    <= pc_d;
      base_q  <= base_d;
      limit_q <= limit_d;
      valid_q <= valid_d;
      if (saved_en) begin
        saved_q <= saved_d;
      end
      if (fault_set) begin
        fault_q <= 1'b1;
      end else if (fault_clr) begin
        fault_q <= 1'b0;
      end
    end
  end

  assign mem_addr    = base_q + pc_q;
  assign pc_logical  = pc_q;
  assign user_mode   = (state_q == StUser);
  assign instr_valid = valid_q;
  assign saved_pc    = saved_q;
  assign fault       = fault_q;
  assign halted      = (state_q == StHalted);

`ifdef FETCH_TRACE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trace_q <= '0;
      redir_q <= RedirNone;
    end else begin
      trace_q <= trace_q + 32'(valid_q);
      if (redir_d != RedirNone) begin
        redir_q <= redir_d;
      end
    end
  end

  assign trace_count       = trace_q;
  assign last_redirect_src = redir_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: scripted stimulus with a queue of expected outputs.
module tb_fetch_pc_unit;

  typedef struct packed {
    logic [31:0] addr;
    logic        um;
    logic        iv;
    logic        f;
    logic [31:0] sp;
    logic        h;
  } obs_t;

  typedef struct packed {
    logic        stall, halt, resume, br, jmp, sys, ctx;
    logic [31:0] off, tgt, cbase, climit, cpc;
  } stim_t;

  logic        clk, rst_n;
  logic        stall, halt, resume, branch_take, jump_take, syscall, ctx_load;
  logic [31:0] branch_off, jump_target, ctx_base, ctx_limit, ctx_pc;
  logic [31:0] mem_addr, pc_logical, saved_pc;
  logic        user_mode, instr_valid, fault, halted;
`ifdef FETCH_TRACE_EN
  logic [31:0] trace_count;
  logic [1:0]  last_redirect_src;
`endif

  int   n_chk = 0;
  int   n_fail = 0;
  obs_t exp_q[$];

  fetch_pc_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .halt        (halt),
    .resume      (resume),
    .branch_take (branch_take),
    .branch_off  (branch_off),
    .jump_take   (jump_take),
    .jump_target (jump_target),
    .syscall     (syscall),
    .ctx_load    (ctx_load),
    .ctx_base    (ctx_base),
    .ctx_limit   (ctx_limit),
    .ctx_pc      (ctx_pc),
    .mem_addr    (mem_addr),
    .pc_logical  (pc_logical),
    .user_mode   (user_mode),
    .instr_valid (instr_valid),
    .saved_pc    (saved_pc),
    .fault       (fault),
    .halted      (halted)
`ifdef FETCH_TRACE_EN
    ,
    .trace_count       (trace_count),
    .last_redirect_src (last_redirect_src)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t ob(int addr, bit um, bit iv, bit f, int sp, bit h);
    ob = '{addr: 32'(addr), um: um, iv: iv, f: f, sp: 32'(sp), h: h};
  endfunction

  function automatic obs_t sample();
    sample = '{addr: mem_addr, um: user_mode, iv: instr_valid, f: fault, sp: saved_pc, h: halted};
  endfunction

  function automatic string fmt(obs_t o);
    fmt = $sformatf("addr=%0d user=%0b iv=%0b fault=%0b saved=%0d halted=%0b",
                    o.addr, o.um, o.iv, o.f, o.sp, o.h);
  endfunction

  function automatic stim_t idle();
    idle = '0;
  endfunction

  function automatic stim_t mk_jmp(int t);
    mk_jmp = '0; mk_jmp.jmp = 1'b1; mk_jmp.tgt = 32'(t);
  endfunction

  function automatic stim_t mk_br(int o);
    mk_br = '0; mk_br.br = 1'b1; mk_br.off = 32'(o);
  endfunction

  function automatic stim_t mk_ctx(int b, int l, int p);
    mk_ctx = '0; mk_ctx.ctx = 1'b1;
    mk_ctx.cbase = 32'(b); mk_ctx.climit = 32'(l); mk_ctx.cpc = 32'(p);
  endfunction

  task automatic apply(input stim_t s);
    stall = s.stall; halt = s.halt; resume = s.resume;
    branch_take = s.br; branch_off = s.off;
    jump_take = s.jmp; jump_target = s.tgt;
    syscall = s.sys; ctx_load = s.ctx;
    ctx_base = s.cbase; ctx_limit = s.climit; ctx_pc = s.cpc;
  endtask

  task automatic test_reset();
    obs_t  got, want;
    stim_t s[$];
    obs_t  e[$];
    apply(idle());
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    got = sample(); want = ob(0, 0, 0, 0, 0, 0);
    n_chk++;
    if (got !== want) begin
      n_fail++; $display("FAIL reset_state: got %s, expected %s", fmt(got), fmt(want));
    end
    rst_n = 1'b1;
    s = '{idle(), idle(), idle()};
    e = '{ob(1, 0, 1, 0, 0, 0), ob(2, 0, 1, 0, 0, 0), ob(3, 0, 1, 0, 0, 0)};
    foreach (s[i]) begin
      apply(s[i]); exp_q.push_back(e[i]);
      @(posedge clk); #1;
      apply(idle());
      got = sample(); want = exp_q.pop_front();
      n_chk++;
      if (got !== want) begin
        n_fail++; $display("FAIL free_run step %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_stall_halt();
    obs_t  got, want;
    stim_t s[$];
    obs_t  e[$];
    stim_t t;
    s.push_back(idle());         e.push_back(ob(4, 0, 1, 0, 0, 0));
    s.push_back(idle());         e.push_back(ob(5, 0, 1, 0, 0, 0));
    t = idle(); t.stall = 1'b1;
    repeat (3) begin
      s.push_back(t);            e.push_back(ob(5, 0, 1, 0, 0, 0));
    end
    t = mk_br(100); t.halt = 1'b1;
    s.push_back(t);              e.push_back(ob(5, 0, 0, 0, 0, 1));
    s.push_back(mk_jmp(50));     e.push_back(ob(5, 0, 0, 0, 0, 1));
    t = idle(); t.resume = 1'b1;
    s.push_back(t);              e.push_back(ob(5, 0, 0, 0, 0, 0));
    t = idle(); t.stall = 1'b1;
    s.push_back(t);              e.push_back(ob(5, 0, 0, 0, 0, 0));
    s.push_back(idle());         e.push_back(ob(6, 0, 1, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]); exp_q.push_back(e[i]);
      @(posedge clk); #1;
      apply(idle());
      got = sample(); want = exp_q.pop_front();
      n_chk++;
      if (got !== want) begin
        n_fail++; $display("FAIL stall_halt step %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_ctx_load();
    obs_t  got, want;
    stim_t s[$];
    obs_t  e[$];
    s = '{mk_ctx(688, 105, 0), idle(), mk_ctx(0, 0, 0)};
    e = '{ob(688, 1, 0, 0, 0, 0), ob(689, 1, 1, 0, 0, 0), ob(690, 1, 1, 0, 0, 0)};
    foreach (s[i]) begin
      apply(s[i]); exp_q.push_back(e[i]);
      @(posedge clk); #1;
      apply(idle());
      got = sample(); want = exp_q.pop_front();
      n_chk++;
      if (got !== want) begin
        n_fail++; $display("FAIL ctx_load step %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_fault();
    obs_t  got, want;
    stim_t s[$];
    obs_t  e[$];
    s = '{mk_jmp(105), mk_jmp(106), idle(), mk_ctx(688, 105, 8), idle(), idle()};
    e = '{ob(793, 1, 0, 0, 0, 0), ob(2, 0, 0, 1, 106, 0), ob(3, 0, 1, 1, 106, 0),
          ob(696, 1, 0, 0, 106, 0), ob(697, 1, 1, 0, 106, 0), ob(698, 1, 1, 0, 106, 0)};
    foreach (s[i]) begin
      apply(s[i]); exp_q.push_back(e[i]);
      @(posedge clk); #1;
      apply(idle());
      got = sample(); want = exp_q.pop_front();
      n_chk++;
      if (got !== want) begin
        n_fail++; $display("FAIL user_fault step %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_syscall();
    obs_t  got, want;
    stim_t s[$];
    obs_t  e[$];
    stim_t t;
    t = mk_jmp(50); t.sys = 1'b1;
    s = '{t, idle()};
    e = '{ob(1, 0, 0, 0, 11, 0), ob(2, 0, 1, 0, 11, 0)};
    foreach (s[i]) begin
      apply(s[i]); exp_q.push_back(e[i]);
      @(posedge clk); #1;
      apply(idle());
      got = sample(); want = exp_q.pop_front();
      n_chk++;
      if (got !== want) begin
        n_fail++; $display("FAIL syscall step %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_branch_bounds();
    obs_t  got, want;
    stim_t s[$];
    obs_t  e[$];
    stim_t t;
    s.push_back(mk_br(10));      e.push_back(ob(12, 0, 0, 0, 11, 0));
    s.push_back(idle());         e.push_back(ob(13, 0, 1, 0, 11, 0));
    s.push_back(mk_br(-5));      e.push_back(ob(8, 0, 0, 0, 11, 0));
    t = mk_jmp(20); t.br = 1'b1; t.off = 32'd100;
    s.push_back(t);              e.push_back(ob(20, 0, 0, 0, 11, 0));
    s.push_back(mk_jmp(999));    e.push_back(ob(999, 0, 0, 0, 11, 0));
    s.push_back(idle());         e.push_back(ob(2, 0, 0, 1, 1000, 0));
    s.push_back(idle());         e.push_back(ob(3, 0, 1, 1, 1000, 0));
    t = idle(); t.sys = 1'b1;
    s.push_back(t);              e.push_back(ob(4, 0, 1, 1, 1000, 0));
    foreach (s[i]) begin
      apply(s[i]); exp_q.push_back(e[i]);
      @(posedge clk); #1;
      apply(idle());
      got = sample(); want = exp_q.pop_front();
      n_chk++;
      if (got !== want) begin
        n_fail++; $display("FAIL branch_bounds step %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t  got, want;
    stim_t s[$];
    obs_t  e[$];
    s = '{mk_ctx(688, 105, 12), idle()};
    e = '{ob(700, 1, 0, 0, 1000, 0), ob(701, 1, 1, 0, 1000, 0)};
    foreach (s[i]) begin
      apply(s[i]); exp_q.push_back(e[i]);
      @(posedge clk); #1;
      apply(idle());
      got = sample(); want = exp_q.pop_front();
      n_chk++;
      if (got !== want) begin
        n_fail++; $display("FAIL reset_mid_pre step %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end
    end
    rst_n = 1'b0;
    #1;
    got = sample(); want = ob(0, 0, 0, 0, 0, 0);
    n_chk++;
    if (got !== want) begin
      n_fail++; $display("FAIL reset_mid_async: got %s, expected %s", fmt(got), fmt(want));
    end
    #3 rst_n = 1'b1;
    exp_q.push_back(ob(1, 0, 1, 0, 0, 0));
    @(posedge clk); #1;
    got = sample(); want = exp_q.pop_front();
    n_chk++;
    if (got !== want) begin
      n_fail++; $display("FAIL reset_mid_restart: got %s, expected %s", fmt(got), fmt(want));
    end
  endtask

  initial begin
    test_reset();
    test_stall_halt();
    test_ctx_load();
    test_fault();
    test_syscall();
    test_branch_bounds();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
